// File: rtl/sc_arb_pkg.sv
// Shared types and default sizing for the multiplier arbiter slice.
// Holds the controller state encoding and the parameter defaults used by every module.
package sc_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam int DEF_DATA_WIDTH     = 4;
   localparam int DEF_OUT_WIDTH      = 8;
   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick, purely combinational: the first request at or after ptr_i wins.
// No backpressure; the result is meaningful only while some request is raised.
module rr_arbiter
   import sc_arb_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic found;
   int   j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // ptr_i < NUM_REQ always, so a single wrap step is enough
         j = int'(ptr_i) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/sc_mul_arbiter.sv
// Round-robin front end for one shared serial multiplier: grant, clear, run, then a one-cycle response.
// Requests wait while busy; mul_en first high 2 cycles after a grant; SC_MUL_ARB_TIMEOUT_EN adds a RUN watchdog.
module sc_mul_arbiter
   import sc_arb_pkg::*;
#(
   parameter  int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter  int OUT_WIDTH      = DEF_OUT_WIDTH,
   parameter  int NUM_REQ        = DEF_NUM_REQ,
   parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   localparam int IDX_W          = $clog2(NUM_REQ)
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NUM_REQ-1:0]                        req,
   input  logic [NUM_REQ-1:0][1:0][DATA_WIDTH-1:0]   op_in,
   output logic [NUM_REQ-1:0]                        gnt,
   output logic                                      rsp_valid,
   output logic [IDX_W-1:0]                          rsp_id,
   output logic [OUT_WIDTH-1:0]                      rsp_data,
   output logic                                      rsp_err,
   output logic                                      mul_rst,
   output logic                                      mul_en,
   output logic [1:0][DATA_WIDTH-1:0]                mul_data_in,
   input  logic [OUT_WIDTH-1:0]                      mul_data_out,
   input  logic                                      mul_done
);

   state_t                      state_q, state_d;
   logic [IDX_W-1:0]            ptr_q, ptr_d;
   logic [IDX_W-1:0]            id_q, id_d;
   logic [1:0][DATA_WIDTH-1:0]  ops_q, ops_d;
   logic [OUT_WIDTH-1:0]        data_q, data_d;
   logic [NUM_REQ-1:0]          arb_gnt;
   logic [IDX_W-1:0]            arb_idx;
   logic                        take;
   logic                        timeout;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx)
   );

   assign take = (state_q == IDLE) && (|req);

`ifdef SC_MUL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign cnt_d   = (state_q == RUN) ? cnt_q + 1'b1 : '0;
   assign rsp_err = err_q;

   always_comb begin
      err_d = err_q;
      if (state_q == RUN) begin
         if (mul_done)     err_d = 1'b0;
         else if (timeout) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
`else
   assign timeout = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (|req) state_d = CLR;
         CLR:     state_d = RUN;
         RUN:     if (mul_done || timeout) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // gnt is gated by rst because IDLE is also the state held throughout reset
   always_comb begin
      gnt       = (state_q == IDLE && !rst) ? arb_gnt : '0;
      mul_rst   = rst | (state_q == CLR);
      mul_en    = (state_q == RUN);
      rsp_valid = (state_q == RESP);
   end

   always_comb begin
      ptr_d  = ptr_q;
      id_d   = id_q;
      ops_d  = ops_q;
      data_d = data_q;
      if (take) begin
         ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
         id_d  = arb_idx;
         ops_d = op_in[arb_idx];
      end
      if (state_q == RUN) begin
         if (mul_done)     data_d = mul_data_out;
         else if (timeout) data_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q  <= '0;
         id_q   <= '0;
         ops_q  <= '0;
         data_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         id_q   <= id_d;
         ops_q  <= ops_d;
         data_q <= data_d;
      end
   end

   assign rsp_id      = id_q;
   assign rsp_data    = data_q;
   assign mul_data_in = ops_q;

endmodule

// File: tb/tb_sc_mul_arbiter.sv
// Randomised bench for sc_mul_arbiter with a stand-in serial multiplier and a response scoreboard.
// Define SC_MUL_ARB_TIMEOUT_EN to also exercise the RUN watchdog.
module tb_sc_mul_arbiter;
   import sc_arb_pkg::*;

   localparam int DW = 4;
   localparam int OW = 8;
   localparam int N  = 4;
   localparam int TO = 16;
   localparam int IW = $clog2(N);

   typedef logic [1:0][DW-1:0] ops_t;
   typedef struct {
      int id;
      int data;
      int err;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [N-1:0]             req = '0;
   logic [N-1:0][1:0][DW-1:0] op_in = '0;
   logic [N-1:0]             gnt;
   logic                     rsp_valid;
   logic [IW-1:0]            rsp_id;
   logic [OW-1:0]            rsp_data;
   logic                     rsp_err;
   logic                     mul_rst;
   logic                     mul_en;
   logic [1:0][DW-1:0]       mul_data_in;
   logic [OW-1:0]            mul_data_out = '0;
   logic                     mul_done = 1'b0;

   sc_mul_arbiter #(
      .DATA_WIDTH(DW), .OUT_WIDTH(OW), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .op_in(op_in), .gnt(gnt),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mul_rst(mul_rst), .mul_en(mul_en), .mul_data_in(mul_data_in),
      .mul_data_out(mul_data_out), .mul_done(mul_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   // stimulus controls, written only by the main process
   bit           auto_on     = 1'b0;
   bit           spurious    = 1'b0;
   bit           no_done     = 1'b0;
   int           auto_div    = 3;
   int           fixed_delay = -1;
   logic [N-1:0] inj         = '0;
   ops_t         inj_ops [N];

   // reference model state, written only by the monitor
   int           cyc       = 0;
   bit           busy      = 1'b0;
   bit           captured  = 1'b0;
   int           ptr_m     = 0;
   int           grant_cyc = -100;
   int           rsp_due   = -100;
   int           cur_id    = 0;
   ops_t         cur_ops   = '0;
   exp_t         exp_q[$];
   int           grant_log[$];
   logic [N-1:0] last_gnt  = '0;
   int           rsp_cnt   = 0;
   int           last_rsp_id = -1, last_rsp_data = -1, last_rsp_err = -1;

   // requesters and the stand-in multiplier
   int en_cnt = 0;
   int cur_delay = 0;
   always @(posedge clk) begin
      #2;
      for (int i = 0; i < N; i++) begin
         if (last_gnt[i]) req[i] = 1'b0;
         if (inj[i]) begin
            req[i]   = 1'b1;
            op_in[i] = inj_ops[i];
         end else if (!req[i] && auto_on && $urandom_range(0, auto_div) == 0) begin
            req[i]      = 1'b1;
            op_in[i][0] = DW'($urandom);
            op_in[i][1] = DW'($urandom);
         end
      end
      if (mul_en && !no_done) begin
         if (en_cnt == cur_delay) begin
            mul_done     = 1'b1;
            mul_data_out = OW'(mul_data_in[0]) * OW'(mul_data_in[1]);
         end else begin
            mul_done = 1'b0;
         end
         en_cnt++;
      end else begin
         en_cnt       = 0;
         cur_delay    = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 10);
         mul_done     = !no_done && spurious && ($urandom_range(0, 3) == 0);
         mul_data_out = OW'($urandom);
      end
   end

   // monitor: predicts grants and strobe timing, pops the scoreboard on rsp_valid
   always @(negedge clk) begin
      int   w;
      bit   en_exp;
      bit   rsp_exp;
      exp_t e;
      if (rst) begin
         busy     = 1'b0;
         captured = 1'b0;
         ptr_m    = 0;
         last_gnt = '0;
         exp_q.delete();
      end else begin
         cyc++;
         last_gnt = gnt;
         for (int k = 0; k < N; k++)
            if (gnt[k]) grant_log.push_back(k);
         en_exp = busy && (cyc >= grant_cyc + 2) && !captured;
         if (!busy) begin
            if (req != '0) begin
               w = rr_pick(req, ptr_m);
               chk("grant", int'(gnt), 1 << w);
               ptr_m     = (w + 1) % N;
               busy      = 1'b1;
               captured  = 1'b0;
               grant_cyc = cyc;
               cur_id    = w;
               cur_ops   = op_in[w];
               e.id   = w;
               e.data = no_done ? 0 : ((int'(cur_ops[0]) * int'(cur_ops[1])) & ((1 << OW) - 1));
               e.err  = no_done ? 1 : 0;
               exp_q.push_back(e);
            end else begin
               chk("grant_none", int'(gnt), 0);
            end
         end else begin
            chk("grant_busy", int'(gnt), 0);
         end
         chk("mul_rst", int'(mul_rst), int'(busy && cyc == grant_cyc + 1));
         chk("mul_en", int'(mul_en), int'(en_exp));
         if (busy && cyc == grant_cyc + 1)
            chk("mul_data_in", int'(mul_data_in), int'(cur_ops));
         if (en_exp && mul_done) begin
            captured = 1'b1;
            rsp_due  = cyc + 1;
         end
`ifdef SC_MUL_ARB_TIMEOUT_EN
         else if (en_exp && cyc == grant_cyc + 1 + TO) begin
            captured = 1'b1;
            rsp_due  = cyc + 1;
         end
`endif
         rsp_exp = busy && captured && (cyc == rsp_due);
         chk("rsp_valid", int'(rsp_valid), int'(rsp_exp));
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_id", int'(rsp_id), e.id);
               chk("rsp_data", int'(rsp_data), e.data);
               chk("rsp_err", int'(rsp_err), e.err);
            end
            last_rsp_id   = int'(rsp_id);
            last_rsp_data = int'(rsp_data);
            last_rsp_err  = int'(rsp_err);
            rsp_cnt++;
         end
         if (rsp_exp) busy = 1'b0;
      end
   end

   task automatic inject(input logic [N-1:0] m);
      @(negedge clk);
      inj = m;
      @(posedge clk);
      #3;
      inj = '0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #4;
         if (req == '0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(nm, int'(ok), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_gnt"}, int'(gnt), 0);
      chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
      chk({tag, "_rsp_id"}, int'(rsp_id), 0);
      chk({tag, "_rsp_data"}, int'(rsp_data), 0);
      chk({tag, "_rsp_err"}, int'(rsp_err), 0);
      chk({tag, "_mul_en"}, int'(mul_en), 0);
      chk({tag, "_mul_rst"}, int'(mul_rst), 1);
      chk({tag, "_mul_data_in"}, int'(mul_data_in), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int base;
      int rbase;
      bit ok;
      for (int i = 0; i < N; i++) inj_ops[i] = '0;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      #2 rst = 1'b0;

      // all four held: 0,1,2,3,0 with one in flight at a time
      base     = grant_log.size();
      auto_div = 0;
      auto_on  = 1'b1;
      for (int i = 0; i < N; i++) begin
         inj_ops[i][0] = DW'(i + 1);
         inj_ops[i][1] = DW'(i + 2);
      end
      inject('1);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #4;
         if (grant_log.size() >= base + 5) begin
            ok = 1'b1;
            break;
         end
      end
      auto_on = 1'b0;
      chk("rr_five_grants", int'(ok), 1);
      if (ok) begin
         chk("rr_order0", grant_log[base + 0], 0);
         chk("rr_order1", grant_log[base + 1], 1);
         chk("rr_order2", grant_log[base + 2], 2);
         chk("rr_order3", grant_log[base + 3], 3);
         chk("rr_order4", grant_log[base + 4], 0);
      end
      wait_idle("rr_drain", 400);

      // wrap-around: grant 2 alone moves ptr to 3, then 1001 -> 3 then 0
      base = grant_log.size();
      inject(4'b0100);
      wait_idle("wrap_first", 100);
      inject(4'b1001);
      wait_idle("wrap_second", 100);
      chk("wrap_cnt", grant_log.size() - base, 3);
      if (grant_log.size() - base == 3) begin
         chk("wrap_g0", grant_log[base + 0], 2);
         chk("wrap_g1", grant_log[base + 1], 3);
         chk("wrap_g2", grant_log[base + 2], 0);
      end

      // single request, operands (3,5), done 8 cycles after mul_en rises
      fixed_delay   = 8;
      inj_ops[0][0] = 4'd3;
      inj_ops[0][1] = 4'd5;
      base          = grant_log.size();
      inject(4'b0001);
      wait_idle("single_done", 100);
      chk("single_gnt_cnt", grant_log.size() - base, 1);
      chk("single_id", last_rsp_id, 0);
      chk("single_data", last_rsp_data, 15);
      chk("single_err", last_rsp_err, 0);
      fixed_delay = -1;

      // random traffic with stray mul_done pulses outside RUN
      spurious = 1'b1;
      auto_div = 3;
      auto_on  = 1'b1;
      rbase    = rsp_cnt;
      repeat (1500) @(posedge clk);
      auto_on = 1'b0;
      wait_idle("rand_drain", 600);
      chk("rand_traffic", int'(rsp_cnt - rbase > 50), 1);
      spurious = 1'b0;

      // reset in the middle of RUN
      inj_ops[1][0] = 4'd7;
      inj_ops[1][1] = 4'd9;
      fixed_delay   = 10;
      inject(4'b0010);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mul_en) begin
            ok = 1'b1;
            break;
         end
      end
      chk("midrun_reached", int'(ok), 1);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_reset_outputs("midrun");
      rbase = rsp_cnt;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      fixed_delay = -1;
      base = grant_log.size();
      inject(4'b0101);
      wait_idle("post_reset", 100);
      chk("post_reset_rsps", rsp_cnt - rbase, 2);
      if (grant_log.size() > base) chk("post_reset_first", grant_log[base], 0);
      else chk("post_reset_first", -1, 0);

`ifdef SC_MUL_ARB_TIMEOUT_EN
      // watchdog: mul_done never arrives
      no_done = 1'b1;
      inj_ops[2][0] = 4'd6;
      inj_ops[2][1] = 4'd6;
      inject(4'b0100);
      wait_idle("timeout_done", TO + 20);
      chk("timeout_err", last_rsp_err, 1);
      chk("timeout_data", last_rsp_data, 0);
      chk("timeout_id", last_rsp_id, 2);
      no_done = 1'b0;
`endif

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
